tone_driver: RTL and testbench

- Sound back-end for the piano datapath. Consumes the 11-bit frequency word (in Hz) that the play-mode blocks produce, and drives a 50%-duty square wave onto the buzzer pin.
- Converts Hz to a half-period count with an iterative sequential divider, so no combinational divider is needed. Retunes cleanly whenever the requested frequency changes.
- A frequency of 0 means silence.

---
 rtl/tone_if.sv | 21 ++
 rtl/tone_driver.sv | 130 +++++++++++++
 tb/tb_tone_driver.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/tone_if.sv
// Tone driver bus: the play-mode side supplies enable and pitch, the driver reports its status.
interface tone_if #(
  parameter int unsigned HALF_W = 26
);
  logic              en;
  logic [10:0]       frequency;
  logic              speaker;
  logic              busy;
  logic              active;
  logic [HALF_W-1:0] half_period;

  modport master (
    output en, frequency,
    input  speaker, busy, active, half_period
  );

  modport slave (
    input  en, frequency,
    output speaker, busy, active, half_period
  );
endinterface

// File: rtl/tone_driver.sv
// Buzzer back-end: turns a frequency in Hz into a 50%-duty square wave.
// The half-period count comes from an iterative restoring divider.
module tone_driver #(
  parameter int unsigned CLK_HZ = 100000000,
  parameter int unsigned HALF_W = 26
) (
  input logic   clk,
  input logic   rst,
  tone_if.slave bus
);

  localparam int unsigned FREQ_W  = 11;
  localparam int unsigned REM_W   = HALF_W + 1;
  localparam int unsigned TRIAL_W = HALF_W + 2;
  localparam int unsigned ITER_W  = $clog2(HALF_W);

  localparam logic [HALF_W-1:0] DIVIDEND  = HALF_W'(CLK_HZ / 2);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(HALF_W - 1);

  typedef enum logic [1:0] {IDLE, DIVIDE, RUN} state_t;

  state_t            state;
  logic [FREQ_W-1:0] freq_q;
  logic [HALF_W-1:0] counter;
  logic [REM_W-1:0]  rem;
  logic [HALF_W-1:0] dvd;
  logic [ITER_W-1:0] iter;
  logic              speaker_q;
  logic              busy_q;
  logic              active_q;
  logic [HALF_W-1:0] half_q;

  logic [TRIAL_W-1:0] trial;
  logic [TRIAL_W-1:0] divisor_x;
  logic [TRIAL_W-1:0] diff;
  logic               fits;
  logic [REM_W-1:0]   next_rem;
  logic [HALF_W-1:0]  next_dvd;

  // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
  // The dividend register doubles as the quotient register, filling from the LSB.
  always_comb begin
    trial     = {rem, dvd[HALF_W-1]};
    divisor_x = TRIAL_W'(freq_q);
    diff      = trial - divisor_x;
    fits      = (trial >= divisor_x);
    next_rem  = fits ? REM_W'(diff) : REM_W'(trial);
    next_dvd  = {dvd[HALF_W-2:0], fits};
  end

  // Control FSM, divider datapath and square-wave generator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      freq_q    <= '0;
      counter   <= '0;
      rem       <= '0;
      dvd       <= '0;
      iter      <= '0;
      speaker_q <= 1'b0;
      busy_q    <= 1'b0;
      active_q  <= 1'b0;
      half_q    <= '0;
    end else if (!bus.en) begin
      state     <= IDLE;
      speaker_q <= 1'b0;
      counter   <= '0;
      freq_q    <= '0;
      busy_q    <= 1'b0;
      active_q  <= 1'b0;
      iter      <= '0;
    end else begin
      case (state)
        IDLE: begin
          speaker_q <= 1'b0;
          if (bus.frequency != '0) begin
            freq_q <= bus.frequency;
            rem    <= '0;
            dvd    <= DIVIDEND;
            iter   <= '0;
            busy_q <= 1'b1;
            state  <= DIVIDE;
          end
        end
        DIVIDE: begin
          rem  <= next_rem;
          dvd  <= next_dvd;
          iter <= iter + ITER_W'(1);
          if (iter == LAST_ITER) begin
            half_q   <= next_dvd;
            counter  <= '0;
            busy_q   <= 1'b0;
            active_q <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (bus.frequency == '0) begin
            state     <= IDLE;
            speaker_q <= 1'b0;
            counter   <= '0;
            freq_q    <= '0;
            active_q  <= 1'b0;
          end else if (bus.frequency != freq_q) begin
            // Retune: speaker keeps its level so no short pulse is emitted.
            freq_q   <= bus.frequency;
            rem      <= '0;
            dvd      <= DIVIDEND;
            iter     <= '0;
            busy_q   <= 1'b1;
            active_q <= 1'b0;
            state    <= DIVIDE;
          end else if (counter == half_q - HALF_W'(1)) begin
            speaker_q <= ~speaker_q;
            counter   <= '0;
          end else begin
            counter <= counter + HALF_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.speaker     = speaker_q;
  assign bus.busy        = busy_q;
  assign bus.active      = active_q;
  assign bus.half_period = half_q;

endmodule

// File: tb/tb_tone_driver.sv
// Scoreboard bench for tone_driver: expected half-periods are queued by the stimulus
// and popped by a monitor at every divide completion; toggle spacing and busy length
// are checked continuously against the same reference values.
module tb_tone_driver;

  localparam int unsigned CLK_HZ   = 20000;
  localparam int unsigned HALF_W   = 14;
  localparam int unsigned HALF_CLK = CLK_HZ / 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tone_if #(.HALF_W(HALF_W)) bus ();

  tone_driver #(.CLK_HZ(CLK_HZ), .HALF_W(HALF_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int sb[$];
  int cur_hp = 0;
  int cur_f  = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: half-period is floor((CLK_HZ/2) / f).
  function automatic void expect_hp(input int f);
    sb.push_back(int'(HALF_CLK) / f);
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_sb_empty(input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL wait_result: %0d results still pending after %0d cycles", sb.size(), budget);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic set_freq(input int f);
    bus.frequency = 11'(f);
  endtask

  // Monitor: busy length, speaker hold during divides, results, toggle spacing.
  int  busy_len  = 0;
  int  gap       = -1;
  bit  prev_busy = 1'b0;
  bit  prev_spk  = 1'b0;
  int  exp_v;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_len  = 0;
        gap       = -1;
        prev_busy = 1'b0;
        prev_spk  = 1'b0;
      end else begin
        if (bus.busy) begin
          busy_len++;
          check("speaker_hold", longint'(bus.speaker), longint'(prev_spk));
        end else if (prev_busy) begin
          if (bus.active) begin
            check("busy_length", busy_len, HALF_W);
            if (sb.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_result: half_period %0d with nothing expected", bus.half_period);
            end else begin
              exp_v = sb.pop_front();
              check("half_period", longint'(bus.half_period), exp_v);
              cur_hp = exp_v;
            end
          end
          busy_len = 0;
        end
        if (!bus.active || bus.busy) begin
          gap = -1;
        end else begin
          gap++;
          if (bus.speaker != prev_spk) begin
            check("toggle_gap", gap, cur_hp);
            gap = 0;
          end
        end
        prev_busy = bus.busy;
        prev_spk  = bus.speaker;
      end
    end
  end

  int f1, f2;

  initial begin
    bus.en        = 1'b0;
    bus.frequency = '0;
    cycles(3);
    check("rst_speaker", longint'(bus.speaker), 0);
    check("rst_busy", longint'(bus.busy), 0);
    check("rst_active", longint'(bus.active), 0);
    check("rst_half_period", longint'(bus.half_period), 0);
    rst = 1'b0;
    cycles(2);

    // Basic tone 440 Hz
    bus.en = 1'b1;
    set_freq(440); cur_f = 440; expect_hp(440);
    wait_sb_empty(100);
    check("active_run", longint'(bus.active), 1);
    cycles(120);

    // Retune while running
    set_freq(1000); cur_f = 1000; expect_hp(1000);
    wait_sb_empty(100);
    cycles(60);

    // Change during divide
    set_freq(440); expect_hp(440);
    wait_sb_empty(100);
    cycles(50);
    set_freq(1000); expect_hp(1000);
    cycles(3);
    set_freq(262); cur_f = 262; expect_hp(262);
    wait_sb_empty(100);
    cycles(60);

    // Silence and enable
    set_freq(0); cur_f = 0;
    cycles(1);
    check("silence_speaker", longint'(bus.speaker), 0);
    check("silence_active", longint'(bus.active), 0);
    bus.en = 1'b0;
    set_freq(523);
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      check("disabled_busy", longint'(bus.busy), 0);
      check("disabled_speaker", longint'(bus.speaker), 0);
    end
    bus.en = 1'b1; cur_f = 523; expect_hp(523);
    wait_sb_empty(100);
    cycles(80);

    // Boundary values
    set_freq(2047); cur_f = 2047; expect_hp(2047);
    wait_sb_empty(100);
    cycles(40);
    set_freq(1); cur_f = 1; expect_hp(1);
    wait_sb_empty(100);
    cycles(20010);

    // Random retunes, some changed again mid-divide
    for (int it = 0; it < 12; it++) begin
      f1 = int'($urandom_range(2047, 1));
      while (f1 == cur_f) f1 = int'($urandom_range(2047, 1));
      set_freq(f1); expect_hp(f1); cur_f = f1;
      if ($urandom_range(1, 0) == 1) begin
        cycles(int'($urandom_range(8, 1)));
        f2 = int'($urandom_range(2047, 1));
        while (f2 == f1) f2 = int'($urandom_range(2047, 1));
        set_freq(f2); expect_hp(f2); cur_f = f2;
      end
      wait_sb_empty(200);
      cycles(int'($urandom_range(200, 20)));
    end

    // Asynchronous reset in the middle of a divide
    set_freq(cur_f == 440 ? 1000 : 440);
    cycles(5);
    check("pre_reset_busy", longint'(bus.busy), 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_speaker", longint'(bus.speaker), 0);
    check("arst_busy", longint'(bus.busy), 0);
    check("arst_active", longint'(bus.active), 0);
    check("arst_half_period", longint'(bus.half_period), 0);
    sb.delete();
    set_freq(440);
    cycles(2);
    rst = 1'b0;
    expect_hp(440);
    wait_sb_empty(100);
    cycles(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
